// File: rtl/maxnet_controller.sv
// rtl/maxnet_controller.sv - sequencing FSM for the N-input float32 Maxnet datapath
// Loads candidates, iterates inhibition until one survivor, none, or the iteration limit.
module maxnet_controller #(
    parameter int N        = 4,
    parameter int FP_LAT   = 3,
    parameter int MAX_ITER = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [N-1:0]                  active,
    output logic                          ld_in,
    output logic                          calc_en,
    output logic                          wr_en,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(N)-1:0]          winner,
    output logic                          winner_valid,
    output logic                          timeout,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_cnt
);
    localparam int WW  = $clog2(N);
    localparam int IW  = $clog2(MAX_ITER + 1);
    localparam int PW  = $clog2(N + 1);
    localparam int WCW = (FP_LAT > 1) ? $clog2(FP_LAT) : 1;
    localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_CALC,
        S_WAIT,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic [PW-1:0]  pop;
    logic [WW-1:0]  idx;

    // Survivor count and index of the lowest surviving neuron (unique when pop == 1).
    always_comb begin
        pop = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (active[i]) begin
                pop = pop + PW'(1);
                idx = WW'(i);
            end
        end
    end

    // Outputs are registered together with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            ld_in        <= 1'b0;
            calc_en      <= 1'b0;
            wr_en        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            winner       <= '0;
            winner_valid <= 1'b0;
            timeout      <= 1'b0;
            iter_cnt     <= '0;
        end else begin
            ld_in   <= 1'b0;
            calc_en <= 1'b0;
            wr_en   <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_LOAD;
                        ld_in        <= 1'b1;
                        busy         <= 1'b1;
                        iter_cnt     <= '0;
                        winner       <= '0;
                        winner_valid <= 1'b0;
                        timeout      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (pop == PW'(1)) begin
                        winner       <= idx;
                        winner_valid <= 1'b1;
                        state        <= S_DONE;
                        done         <= 1'b1;
                    end else if (pop == '0) begin
                        winner_valid <= 1'b0;
                        state        <= S_DONE;
                        done         <= 1'b1;
                    end else if (iter_cnt == ITER_MAX) begin
                        timeout <= 1'b1;
                        state   <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        state   <= S_CALC;
                        calc_en <= 1'b1;
                    end
                end
                S_CALC: begin
                    wait_cnt <= WCW'(FP_LAT - 1);
                    if (FP_LAT == 1) begin
                        state <= S_COMMIT;
                        wr_en <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - WCW'(1);
                    if (wait_cnt == WCW'(1)) begin
                        state <= S_COMMIT;
                        wr_en <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    if (iter_cnt != ITER_MAX) begin
                        iter_cnt <= iter_cnt + IW'(1);
                    end
                    state <= S_CHECK;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
